// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared opcode, state and JK encoding definitions for jk_sequencer
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET      = 3'd1,
    OP_CLEAR    = 3'd2,
    OP_TOGGLE   = 3'd3,
    OP_COUNT_UP = 3'd4,
    OP_COUNT_DN = 3'd5,
    OP_RSV6     = 3'd6,
    OP_RSV7     = 3'd7
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } jk_state_e;

  // {j, k} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  function automatic logic [1:0] op_jk_pair(input jk_op_e op);
    case (op)
      OP_SET:    return JK_SET;
      OP_CLEAR:  return JK_CLR;
      OP_TOGGLE: return JK_TOG;
      default:   return JK_HOLD;
    endcase
  endfunction

  function automatic logic is_count_op(input jk_op_e op);
    return (op == OP_COUNT_UP) || (op == OP_COUNT_DN);
  endfunction

endpackage

// File: rtl/jk_bank.sv
// rtl/jk_bank.sv - bank of WIDTH JK flip-flops with shared clock and async active-low reset
module jk_bank
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          JK_SET:  q[i] <= 1'b1;
          JK_CLR:  q[i] <= 1'b0;
          JK_TOG:  q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_sequencer.sv
// rtl/jk_sequencer.sv - command FSM that drives a JK flip-flop bank for set/clear/toggle/count ops
module jk_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [7:0]       cmd_count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  jk_state_e        state_q;
  jk_state_e        state_d;
  jk_op_e           op_q;
  jk_op_e           cmd_op_e;
  logic [WIDTH-1:0] mask_q;
  logic [7:0]       remaining_q;
  logic             accept;
  logic [WIDTH-1:0] bank_j;
  logic [WIDTH-1:0] bank_k;
  logic [WIDTH-1:0] count_tog;
  logic             carry;
  logic [1:0]       apply_pair;

  assign cmd_op_e = jk_op_e'(cmd_op);
  assign accept   = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_NOP;
      mask_q      <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      op_q        <= cmd_op_e;
      mask_q      <= cmd_mask;
      remaining_q <= cmd_count;
    end else if (state_q == ST_COUNT) begin
      remaining_q <= remaining_q - 8'd1;
    end
  end

  // Ripple over masked bits only: unmasked positions are skipped, so the
  // masked bits behave as one packed binary counter with wrap-around.
  always_comb begin
    count_tog = '0;
    carry     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_q[i]) begin
        count_tog[i] = carry;
        carry = carry & ((op_q == OP_COUNT_UP) ? q[i] : ~q[i]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    bank_j     = '0;
    bank_k     = '0;
    apply_pair = op_jk_pair(op_q);
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (is_count_op(cmd_op_e)) begin
            state_d = (cmd_count == 8'd0) ? ST_DONE : ST_COUNT;
          end else begin
            state_d = ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        busy    = 1'b1;
        state_d = ST_DONE;
        for (int i = 0; i < WIDTH; i++) begin
          if (mask_q[i]) begin
            {bank_j[i], bank_k[i]} = apply_pair;
          end
        end
      end
      ST_COUNT: begin
        busy   = 1'b1;
        bank_j = count_tog;
        bank_k = count_tog;
        if (remaining_q == 8'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .j    (bank_j),
    .k    (bank_k),
    .q    (q)
  );

endmodule

// File: tb/tb_jk_sequencer.sv
// tb/tb_jk_sequencer.sv - directed table-driven testbench for jk_sequencer
module tb_jk_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_count;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  logic [3:0] mq;

  typedef struct {
    logic [2:0] op;
    logic [3:0] mask;
    logic [7:0] cnt;
    logic [3:0] exp_q;
    int         exp_lat;
  } vec_t;

  vec_t vecs[14];

  jk_sequencer #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_count(cmd_count),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: gather masked bits into a packed value, add/subtract, scatter back.
  function automatic logic [3:0] model_step(input logic [3:0] cur, input logic [2:0] op,
                                            input logic [3:0] mask);
    logic [3:0] pv;
    logic [3:0] r;
    int n;
    case (op)
      3'd1: return cur | mask;
      3'd2: return cur & ~mask;
      3'd3: return cur ^ mask;
      3'd4, 3'd5: begin
        pv = '0;
        n = 0;
        for (int i = 0; i < 4; i++) if (mask[i]) begin pv[n] = cur[i]; n++; end
        pv = (op == 3'd4) ? pv + 4'd1 : pv - 4'd1;
        r = cur;
        n = 0;
        for (int i = 0; i < 4; i++) if (mask[i]) begin r[i] = pv[n]; n++; end
        return r;
      end
      default: return cur;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready"}, cmd_ready, 1);
  endtask

  task automatic run_cmd(input vec_t v, input string name);
    int lat;
    int busy_n;
    int steps;
    bit got;
    @(negedge clk);
    wait_ready(name);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_mask  = v.mask;
    cmd_count = v.cnt;
    steps = (v.op == 3'd4 || v.op == 3'd5) ? int'(v.cnt) : 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({name, "_q_e0"}, q, mq);
    lat = 0;
    busy_n = 0;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (done) begin
        got = 1;
      end else begin
        if (busy) busy_n++;
        @(posedge clk);
        #1;
        lat++;
        if (lat <= steps) begin
          mq = model_step(mq, v.op, v.mask);
          chk({name, "_q_step"}, q, mq);
        end
      end
    end
    chk({name, "_done_seen"}, got, 1);
    chk({name, "_latency"}, lat, v.exp_lat);
    chk({name, "_busy_cycles"}, busy_n, v.exp_lat);
    chk({name, "_q_final"}, q, v.exp_q);
    @(posedge clk);
    #1;
    chk({name, "_done_1cyc"}, done, 0);
    chk({name, "_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    int done_cnt;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_mask  = '0;
    cmd_count = '0;
    mq        = '0;

    vecs[0]  = '{3'd1, 4'b0101, 8'd0,  4'b0101, 1};
    vecs[1]  = '{3'd3, 4'b1111, 8'd0,  4'b1010, 1};
    vecs[2]  = '{3'd2, 4'b0010, 8'd0,  4'b1000, 1};
    vecs[3]  = '{3'd0, 4'b1111, 8'd0,  4'b1000, 1};
    vecs[4]  = '{3'd6, 4'b1111, 8'd5,  4'b1000, 1};
    vecs[5]  = '{3'd1, 4'b0000, 8'd0,  4'b1000, 1};
    vecs[6]  = '{3'd2, 4'b1111, 8'd0,  4'b0000, 1};
    vecs[7]  = '{3'd4, 4'b1111, 8'd18, 4'b0010, 18};
    vecs[8]  = '{3'd2, 4'b1111, 8'd0,  4'b0000, 1};
    vecs[9]  = '{3'd5, 4'b1010, 8'd1,  4'b1010, 1};
    vecs[10] = '{3'd4, 4'b1111, 8'd0,  4'b1010, 0};
    vecs[11] = '{3'd4, 4'b0110, 8'd3,  4'b1000, 3};
    vecs[12] = '{3'd5, 4'b1001, 8'd2,  4'b0000, 2};
    vecs[13] = '{3'd5, 4'b0000, 8'd1,  4'b0000, 1};

    #2;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // count=0 with cmd_valid held high: second command waits until after done
    @(negedge clk);
    wait_ready("hold");
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_mask  = 4'b1111;
    cmd_count = 8'd0;
    @(posedge clk);
    #1;
    chk("hold_done_e0", done, 1);
    chk("hold_ready_e0", cmd_ready, 0);
    chk("hold_q_e0", q, 4'b0000);
    cmd_op   = 3'd1;
    cmd_mask = 4'b0011;
    @(posedge clk);
    #1;
    chk("hold_ready_e1", cmd_ready, 1);
    chk("hold_busy_e1", busy, 0);
    chk("hold_done_e1", done, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("hold_busy_e2", busy, 1);
    chk("hold_q_e2", q, 4'b0000);
    @(posedge clk);
    #1;
    chk("hold_q_e3", q, 4'b0011);
    chk("hold_done_e3", done, 1);
    mq = 4'b0011;
    @(posedge clk);
    #1;

    // reset mid-COUNT at step 3 of 10
    @(negedge clk);
    wait_ready("abort");
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_mask  = 4'b1111;
    cmd_count = 8'd10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_q_step3", q, 4'b0110);
    chk("abort_busy_step3", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_q_async", q, 0);
    chk("abort_busy_async", busy, 0);
    chk("abort_done_async", done, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mq = '0;
    #1;
    chk("abort_ready", cmd_ready, 1);
    done_cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_q_hold", q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
